// File: rtl/nand_cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : nand_cpu_pkg                                                  |
// | Purpose  : Shared widths, defaults and state encoding for the data-side |
// |            memory responder.                                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package nand_cpu_pkg;

  localparam int C_WORD_W          = 8;
  localparam int C_ADDR_W          = 8;
  localparam int C_DEFAULT_LATENCY = 2;
  localparam int C_CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } d_mem_state_t;

  // A single-word array still needs a one-bit index to keep port widths legal.
  function automatic int d_mem_idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/d_mem_array.sv
// +--------------------------------------------------------------------------+
// | Module   : d_mem_array                                                   |
// | Purpose  : WORDS x 8 storage, one synchronous write port, one            |
// |            asynchronous read port, contents not reset.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module d_mem_array
  import nand_cpu_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [C_WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [C_WORD_W-1:0] rdata
);

  logic [C_WORD_W-1:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/d_mem_responder.sv
// +--------------------------------------------------------------------------+
// | Module   : d_mem_responder                                               |
// | Purpose  : Fixed-latency single-outstanding memory responder for the     |
// |            d_cache. Define D_MEM_ERR_EN to add resp_err and bounds check.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module d_mem_responder
  import nand_cpu_pkg::*;
#(
  parameter int LATENCY   = C_DEFAULT_LATENCY,
  parameter int MEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [C_ADDR_W-1:0] req_addr,
  input  logic [C_WORD_W-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [C_WORD_W-1:0] resp_rdata
`ifdef D_MEM_ERR_EN
  ,
  output logic                resp_err
`endif
);

  localparam int                 C_IDX_W    = d_mem_idx_w(MEM_WORDS);
  localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  d_mem_state_t        r_state;
  d_mem_state_t        w_next_state;
  logic [C_CNT_W-1:0]  r_cnt;
  logic                r_write;
  logic [C_ADDR_W-1:0] r_addr;
  logic [C_WORD_W-1:0] r_wdata;
  logic [C_WORD_W-1:0] r_resp_rdata;

  logic                w_accept;
  logic                w_commit;
  logic                w_we;
  logic                w_oob;
  logic                w_op_write;
  logic [C_ADDR_W-1:0] w_op_addr;
  logic [C_WORD_W-1:0] w_op_wdata;
  logic [C_WORD_W-1:0] w_rd_word;
  logic [C_IDX_W-1:0]  w_idx;

  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_resp_rdata;
  assign w_accept   = req_valid && req_ready;

  // With zero latency the commit happens on the accept edge, so use the live bus.
  assign w_op_write = (r_state == IDLE) ? req_write : r_write;
  assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

  assign w_commit = ((r_state == WAIT) && (r_cnt == '0)) || ((LATENCY == 0) && w_accept);
  assign w_we     = w_commit && w_op_write && !w_oob;

  generate
    if (MEM_WORDS > 1) begin : g_idx_addr
      assign w_idx = w_op_addr[C_IDX_W-1:0];
    end else begin : g_idx_single
      assign w_idx = '0;
    end
  endgenerate

`ifdef D_MEM_ERR_EN
  logic r_resp_err;

  assign w_oob    = ({24'd0, w_op_addr} >= 32'(MEM_WORDS));
  assign resp_err = r_resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_err <= 1'b0;
    end else if (w_commit) begin
      r_resp_err <= w_oob;
    end
  end
`else
  assign w_oob = 1'b0;
`endif

  d_mem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (C_IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_idx),
    .wdata (w_op_wdata),
    .raddr (w_idx),
    .rdata (w_rd_word)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= C_CNT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Stores echo their data; out-of-range loads read as zero.
      if (w_commit) begin
        r_resp_rdata <= w_op_write ? w_op_wdata : (w_oob ? '0 : w_rd_word);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_d_mem_responder.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_d_mem_responder                                            |
// | Purpose  : Directed bench for d_mem_responder (three parameter sets).    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_d_mem_responder;

  logic             clk;
  logic [2:0]       rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0]       req_write;
  logic [2:0][7:0]  req_addr;
  logic [2:0][7:0]  req_wdata;
  logic [2:0]       resp_valid;
  logic [2:0]       resp_ready;
  logic [2:0][7:0]  resp_rdata;
`ifdef D_MEM_ERR_EN
  logic [2:0]       resp_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [7:0] model [256];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: LATENCY 2 / 256 words, u1: LATENCY 0, u2: LATENCY 2 / 16 words
  d_mem_responder #(.LATENCY(2), .MEM_WORDS(256)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0])
`ifdef D_MEM_ERR_EN
    , .resp_err(resp_err[0])
`endif
  );

  d_mem_responder #(.LATENCY(0), .MEM_WORDS(256)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1])
`ifdef D_MEM_ERR_EN
    , .resp_err(resp_err[1])
`endif
  );

  d_mem_responder #(.LATENCY(2), .MEM_WORDS(16)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2])
`ifdef D_MEM_ERR_EN
    , .resp_err(resp_err[2])
`endif
  );

  function automatic int lat_of(input int d);
    return (d == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request through handshake; checks latency, data, error and re-ready.
  task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] exp_rd, input bit exp_err, input string nm);
    int n;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    resp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_accept"}, 32'(req_ready[d]), 32'd1);
    if (!req_ready[d]) begin
      req_valid[d] = 1'b0;
      return;
    end
    tick();
    req_valid[d] = 1'b0;
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat_of(d)));
    chk({nm, "_rdata"}, 32'(resp_rdata[d]), 32'(exp_rd));
`ifdef D_MEM_ERR_EN
    chk({nm, "_err"}, 32'(resp_err[d]), 32'(exp_err));
`else
    if (exp_err) $display("note: %s expects err but resp_err is absent", nm);
`endif
    tick();
    chk({nm, "_ready_after"}, 32'(req_ready[d]), 32'd1);
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int t;
    int last;
    rst        = 3'b111;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '0;

    tbl[0] = '{1'b0, 8'h00, 8'h00, 8'hC3};
    tbl[1] = '{1'b1, 8'h10, 8'hA5, 8'hA5};
    tbl[2] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[3] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
    tbl[4] = '{1'b1, 8'h33, 8'h5C, 8'h5C};
    tbl[5] = '{1'b0, 8'h33, 8'h00, 8'h5C};
    tbl[6] = '{1'b1, 8'h80, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 8'h80, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 8'h81, 8'h00, 8'h42};

    // reset state
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd0);
      chk($sformatf("rst_resp_valid%0d", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), 32'(resp_rdata[d]), 32'd0);
    end
    rst = 3'b000;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_ready%0d", d), 32'(req_ready[d]), 32'd1);
    end

    // fill u0 with addr ^ 0xC3
    for (int i = 0; i < 256; i++) begin
      model[i] = 8'(i) ^ 8'hC3;
      txn(0, 1'b1, 8'(i), 8'(i) ^ 8'hC3, 8'(i) ^ 8'hC3, 1'b0, "fill");
    end

    for (int i = 0; i < 9; i++) begin
      txn(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
      if (tbl[i].wr) model[tbl[i].addr] = tbl[i].wdata;
    end

    // held request with a new address during WAIT is only taken after the handshake
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h10; resp_ready[0] = 1'b0;
    tick();
    req_addr[0] = 8'h33;
    n = 1;
    while (!resp_valid[0] && n < 40) begin
      chk("hold_ready_low_wait", 32'(req_ready[0]), 32'd0);
      tick();
      n++;
    end
    chk("hold_first_lat", 32'(n), 32'd3);
    chk("hold_first_rdata", 32'(resp_rdata[0]), 32'(model[8'h10]));
    chk("hold_ready_low_resp", 32'(req_ready[0]), 32'd0);
    resp_ready[0] = 1'b1;
    tick();
    chk("hold_ready_after_hs", 32'(req_ready[0]), 32'd1);
    chk("hold_valid_after_hs", 32'(resp_valid[0]), 32'd0);
    tick();
    req_valid[0] = 1'b0;
    n = 1;
    while (!resp_valid[0] && n < 40) begin
      tick();
      n++;
    end
    chk("hold_second_lat", 32'(n), 32'd3);
    chk("hold_second_rdata", 32'(resp_rdata[0]), 32'(model[8'h33]));
    tick();
    resp_ready[0] = 1'b0;

    // reset during WAIT of a store drops it
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h20; req_wdata[0] = 8'h3C;
    tick();
    req_valid[0] = 1'b0;
    #2 rst[0] = 1'b1;
    #1;
    chk("rstwait_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rstwait_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rstwait_rdata", 32'(resp_rdata[0]), 32'd0);
    rst[0] = 1'b0;
    tick();
    chk("rstwait_ready_after", 32'(req_ready[0]), 32'd1);
    tick();
    tick();
    chk("rstwait_no_resp", 32'(resp_valid[0]), 32'd0);
    txn(0, 1'b0, 8'h20, 8'h00, 8'hE3, 1'b0, "rstwait_load");

    // back-to-back loads, one response every LATENCY+2 cycles, in order
    req_valid[0] = 1'b1; req_write[0] = 1'b0; resp_ready[0] = 1'b1;
    last = 0;
    for (int i = 0; i < 256; i++) begin
      req_addr[0] = 8'(i);
      n = 0;
      while (!req_ready[0] && n < 20) begin
        tick();
        n++;
      end
      if (!req_ready[0]) begin
        chk("b2b_accept", 32'(req_ready[0]), 32'd1);
        break;
      end
      tick();
      t = cyc;
      if (i > 0) chk($sformatf("b2b_period%0d", i), 32'(t - last), 32'd4);
      last = t;
      n = 1;
      while (!resp_valid[0] && n < 40) begin
        tick();
        n++;
      end
      chk($sformatf("b2b_rdata%0d", i), 32'(resp_rdata[0]), 32'(model[i]));
      tick();
    end
    req_valid[0] = 1'b0; resp_ready[0] = 1'b0;

    // LATENCY 0: stalled response held stable
    txn(1, 1'b1, 8'h44, 8'h9D, 8'h9D, 1'b0, "l0_store");
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h44; resp_ready[1] = 1'b0;
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_valid%0d", k), 32'(resp_valid[1]), 32'd1);
      chk($sformatf("stall_rdata%0d", k), 32'(resp_rdata[1]), 32'h9D);
      chk($sformatf("stall_ready%0d", k), 32'(req_ready[1]), 32'd0);
      if (k < 3) tick();
    end
    resp_ready[1] = 1'b1;
    tick();
    chk("stall_valid_done", 32'(resp_valid[1]), 32'd0);
    chk("stall_ready_done", 32'(req_ready[1]), 32'd1);
    resp_ready[1] = 1'b0;

    // 16-word array: out-of-range store
    txn(2, 1'b1, 8'h05, 8'h11, 8'h11, 1'b0, "m16_st05");
`ifdef D_MEM_ERR_EN
    txn(2, 1'b1, 8'h15, 8'h77, 8'h77, 1'b1, "m16_st15");
    txn(2, 1'b0, 8'h05, 8'h00, 8'h11, 1'b0, "m16_ld05");
    txn(2, 1'b0, 8'h15, 8'h00, 8'h00, 1'b1, "m16_ld15");
`else
    txn(2, 1'b1, 8'h15, 8'h77, 8'h77, 1'b0, "m16_st15");
    txn(2, 1'b0, 8'h05, 8'h00, 8'h77, 1'b0, "m16_ld05");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/d_mem_responder.md
D_MEM_RESPONDER -- requirements
Module: d_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning the number of wait cycles between request accept and response valid (legal range 0..15).
REQ-002 SHALL have parameter MEM_WORDS, default 256, meaning the number of 8-bit words backed (legal range 1..256).
REQ-003 SHALL have port clk, input, width 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, width 1, an asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, width 1, asserted when the d_cache request is valid.
REQ-006 SHALL have port req_ready, output, width 1, asserted when the responder accepts a request.
REQ-007 SHALL have port req_write, input, width 1, 1=store, 0=load.
REQ-008 SHALL have port req_addr, input, width 8, the word address.
REQ-009 SHALL have port req_wdata, input, width 8, the store data.
REQ-010 SHALL have port resp_valid, output, width 1, asserted when a response is presented.
REQ-011 SHALL have port resp_ready, input, width 1, asserted when the requester consumes the response.
REQ-012 SHALL have port resp_rdata, output, width 8, carrying load data, or the written data for a store.
REQ-013 SHALL have port resp_err, output, width 1, as defined in REQ-027; it is present only when D_MEM_ERR_EN is defined.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP, with exactly one request outstanding at a time.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on any edge where req_valid&&req_ready.
REQ-016 SHALL, on accept, latch write, addr and wdata; if LATENCY>0 go to WAIT and load the counter with LATENCY-1, otherwise go to RESP.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-018 SHALL commit a store to the array on the edge that leaves WAIT (or the edge of accept when LATENCY=0).
REQ-019 SHALL make a load return the array word read on that same edge into the response register.
REQ-020 SHALL give a response first visible LATENCY+1 cycles after the accept edge.
REQ-021 SHALL, in RESP, hold resp_valid=1 and keep resp_rdata/resp_err stable until resp_ready=1.
REQ-022 SHALL return to IDLE on the edge where resp_valid&&resp_ready; req_ready rises one cycle later (no same-cycle overlap).
REQ-023 SHALL ignore req_* in WAIT and RESP; the requester holds its request until accepted.
REQ-024 SHALL use only addr[ceil(log2 MEM_WORDS)-1:0] for array indexing; addresses >= MEM_WORDS wrap modulo 2^index width.
REQ-025 SHALL make a load that immediately follows a store to the same address return the new data.

Reset
REQ-026 SHALL, on rst asserted at any time, force the state to IDLE, req_ready=0 while rst is high then 1, resp_valid=0, resp_rdata=0, resp_err=0 and the counter to 0; any in-flight request is dropped with no array write if not yet committed; array contents are not reset.

Configuration
REQ-027 SHALL, with D_MEM_ERR_EN defined, provide resp_err=1 when addr>=MEM_WORDS; such stores do not write the array and such loads return rdata=0.
REQ-028 SHALL, with D_MEM_ERR_EN undefined, omit resp_err and apply the wrap rule of REQ-024.

Structure
REQ-029 SHALL place the state enum d_mem_state_t, the 8-bit word/address widths and the default LATENCY in nand_cpu_pkg, visible through nand_cpu.svh.
REQ-030 SHALL implement storage in sub-module d_mem_array (one synchronous write port, one read port, MEM_WORDS x 8, no reset).

Verification
REQ-031 SHALL be covered by a bench scenario: LATENCY=2, store addr 0x10 data 0xA5, then load 0x10 -> store response rdata=0xA5 at accept+3, load response rdata=0xA5 at accept+3.
REQ-032 SHALL be covered by a bench scenario: LATENCY=0, load then resp_ready held low for 4 cycles -> resp_valid held 4 cycles with rdata stable and req_ready=0 throughout.
REQ-033 SHALL be covered by a bench scenario: req_valid held during WAIT with a different addr -> that request is not accepted until the cycle after the response handshake.
REQ-034 SHALL be covered by a bench scenario: rst pulsed in WAIT of a store of 0x3C to 0x20 -> resp_valid=0 and a later load of 0x20 returns the pre-store value.
REQ-035 SHALL be covered by a bench scenario: MEM_WORDS=16, D_MEM_ERR_EN defined, store to 0x15 -> resp_err=1 and a load of 0x05 is unchanged; with the macro undefined -> the load of 0x05 returns the stored data.
REQ-036 SHALL be covered by a bench scenario: back-to-back loads of 0x00..0xFF with resp_ready=1 -> one response every LATENCY+2 cycles, in order.
